// File: rtl/dist_ram.sv
// dist_ram: single-port distributed RAM with synchronous write, combinational read and an
// asynchronous active-high reset that clears every word.
module dist_ram #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] spo
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] mem_d [Depth];

  // Next-state array: only the addressed word changes, and only when writing.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[a] = d;
    end
  end

  // Storage update; reset wins over any write and clears the whole array at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous read port: address changes and completed writes show up without a clock.
  always_comb begin
    spo = mem_q[a];
  end

endmodule

// File: tb/tb_dist_ram.sv
// tb_dist_ram: self-checking bench for dist_ram (table vectors, directed corners, random vs model).
module tb_dist_ram;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic          we;
  logic [DW-1:0] spo;

  int total = 0;
  int bad   = 0;

  // Reference contents: plain array, cleared by reset, updated on each enabled edge.
  logic [DW-1:0] model [DEPTH];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wen;
    logic [DW-1:0] exp_spo;
  } vec_t;

  vec_t vecs [8];

  dist_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .d  (d),
    .we (we),
    .spo(spo)
  );

  always #2 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One write over a single rising edge; inputs change only mid-cycle.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    a  = addr;
    d  = data;
    we = 1'b1;
    @(posedge clk);
    if (!rst) model[addr] = data;
    #1;
    we = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    vecs[0] = '{addr: 6'd0, data: 16'h00AA, wen: 1'b1, exp_spo: 16'h00AA};
    vecs[1] = '{addr: 6'd1, data: 16'h00CC, wen: 1'b1, exp_spo: 16'h00CC};
    vecs[2] = '{addr: 6'd0, data: 16'h1111, wen: 1'b0, exp_spo: 16'h00AA};
    vecs[3] = '{addr: 6'd1, data: 16'h2222, wen: 1'b0, exp_spo: 16'h00CC};
    vecs[4] = '{addr: 6'd2, data: 16'h0022, wen: 1'b1, exp_spo: 16'h0022};
    vecs[5] = '{addr: 6'd1, data: 16'h0000, wen: 1'b0, exp_spo: 16'h00CC};
    vecs[6] = '{addr: 6'd0, data: 16'hFFFF, wen: 1'b0, exp_spo: 16'h00AA};
    vecs[7] = '{addr: 6'd2, data: 16'h0000, wen: 1'b0, exp_spo: 16'h0022};

    a  = '0;
    d  = '0;
    we = 1'b0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    clear_model();

    // Reset sweep: every address reads zero.
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      #1;
      check("reset_sweep", spo, 16'h0000);
    end

    @(negedge clk);
    rst = 1'b0;

    // Table vectors: apply over one edge, check the addressed word just after it.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a  = vecs[i].addr;
      d  = vecs[i].data;
      we = vecs[i].wen;
      @(posedge clk);
      if (vecs[i].wen) model[vecs[i].addr] = vecs[i].data;
      #1;
      we = 1'b0;
      check($sformatf("vec%0d", i), spo, vecs[i].exp_spo);
    end

    // Write-enable gating over several edges.
    @(negedge clk);
    a = 6'd0; d = 16'hFFFF; we = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("we_gate", spo, 16'h00AA);

    // Read-during-write on one address: old word before the edge, new word after.
    do_write(6'd3, 16'h1234);
    @(negedge clk);
    a = 6'd3; d = 16'h5678; we = 1'b1;
    #1;
    check("rdw_before", spo, 16'h1234);
    @(posedge clk);
    model[3] = 16'h5678;
    #1;
    we = 1'b0;
    check("rdw_after", spo, 16'h5678);

    // Combinational address change between edges.
    @(negedge clk);
    a = 6'd2;
    #1;
    check("addr_comb", spo, 16'h0022);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic          rw;
      ra = AW'($urandom_range(0, DEPTH - 1));
      rd = DW'($urandom);
      rw = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      a = ra; d = rd; we = rw;
      #1;
      check("rand_before", spo, model[ra]);
      @(posedge clk);
      if (rw) model[ra] = rd;
      #1;
      we = 1'b0;
      check("rand_after", spo, model[ra]);
    end

    // Sweep back every word against the model.
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      #1;
      check("rand_sweep", spo, model[i]);
    end

    // Async reset mid-operation, between edges.
    do_write(6'd0, 16'h0A0A);
    do_write(6'd1, 16'h1B1B);
    do_write(6'd2, 16'h2C2C);
    do_write(6'd3, 16'h3D3D);
    @(negedge clk);
    a = 6'd3;
    #1;
    check("pre_rst_word3", spo, 16'h3D3D);
    rst = 1'b1;
    clear_model();
    #0.5;
    check("rst_immediate", spo, 16'h0000);

    // Write attempted while reset is held is ignored.
    @(negedge clk);
    a = 6'd5; d = 16'hBEEF; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_write_ignored", spo, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      a = AW'(i);
      #0.25;
      check("post_rst_word", spo, 16'h0000);
    end

    // Normal writes resume after deassertion.
    do_write(6'd5, 16'hCAFE);
    a = 6'd5;
    #1;
    check("post_rst_write", spo, 16'hCAFE);
    a = 6'd4;
    #0.5;
    check("post_rst_neighbour", spo, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
